fifo_salida: RTL and testbench

//   Output FIFO for one egress lane. Buffers 10-bit words from the switching logic.

---
 rtl/fifo_salida.sv | 113 +++++++++++
 tb/tb_fifo_salida.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_salida.sv
// fifo_salida: output FIFO for one egress lane.
// Registered read port with a one-cycle valid_out pulse per popped word, an
// occupancy counter with threshold flags, and a sticky overflow/underflow
// error bit. The memory itself has no reset; only pointers and outputs clear.
module fifo_salida #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned UMBRAL_ALTO = 6,
    parameter int unsigned UMBRAL_BAJO = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic pop_ok;
    logic push_ok;

    // Status flags decoded from the registered occupancy
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(UMBRAL_ALTO));
    assign almost_empty = (count_q <= CW'(UMBRAL_BAJO));

    // A full FIFO still takes a push when the same edge frees a slot
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state computation for pointers, occupancy, read port and error
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Dropped push or rejected pop latches the error until reset
        if ((push && !push_ok) || (pop && empty)) begin
            error_d = 1'b1;
        end
    end

    // Control and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage write; contents are irrelevant after reset so no clear
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign count     = count_q;
    assign error     = error_q;

endmodule

// File: tb/tb_fifo_salida.sv
// Testbench for fifo_salida: directed scenarios plus random traffic, checked
// against a queue-based reference model of the lane FIFO.
module tb_fifo_salida;

    localparam int unsigned DW    = 10;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_err;

    fifo_salida dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the behavioural FIFO: reset clears, pop reads the oldest,
    // push appends if there is room (or room is being freed this edge)
    task automatic model_edge(input logic r, input logic pu, input logic [DW-1:0] d, input logic po);
        bit pop_ok;
        bit push_ok;
        if (!r) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            pop_ok  = po && (m_q.size() > 0);
            push_ok = pu && ((m_q.size() < DEPTH) || pop_ok);
            if ((pu && !push_ok) || (po && m_q.size() == 0)) m_err = 1'b1;
            if (pop_ok) begin
                m_dout  = DW'(m_q.pop_front());
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (push_ok) m_q.push_back(int'(d));
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("valid_out",    32'(valid_out),    32'(m_valid));
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("error",        32'(error),        32'(m_err));
    endtask

    task automatic step(input logic r, input logic pu, input logic [DW-1:0] d, input logic po);
        reset   = r;
        push    = pu;
        data_in = d;
        pop     = po;
        @(posedge clk);
        model_edge(r, pu, d, po);
        #1;
        check_model();
    endtask

    initial begin
        logic [DW-1:0] prev;
        reset   = 1'b0;
        push    = 1'b1;
        pop     = 1'b1;
        data_in = DW'(10'h123);

        // Reset held 3 cycles with push and pop active
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'($urandom), 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout",  32'(data_out), 32'd0);

        // Fill 1..8 then drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, DW'(i), 1'b0);
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
        end
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            chk("drain_data",  32'(data_out),  32'(i));
            chk("drain_valid", 32'(valid_out), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Overflow at full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'($urandom_range(0, 10'h3FE)), 1'b0);
        step(1'b1, 1'b1, DW'(10'h3FF), 1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_error", 32'(error), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            chk("ovf_no3ff", 32'(data_out != DW'(10'h3FF)), 32'd1);
        end

        // Underflow on empty
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, DW'(10'h2C3), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        prev = data_out;
        step(1'b1, 1'b0, '0, 1'b1);
        chk("unf_valid", 32'(valid_out), 32'd0);
        chk("unf_dout",  32'(data_out),  32'(prev));
        chk("unf_error", 32'(error),     32'd1);

        // Simultaneous push+pop at full, then at empty
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'(10'h040 + i), 1'b0);
        step(1'b1, 1'b1, DW'(10'h155), 1'b1);
        chk("sim_full_count", 32'(count),    32'd8);
        chk("sim_full_data",  32'(data_out), 32'h040);
        chk("sim_full_error", 32'(error),    32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, DW'(10'h0F0), 1'b1);
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_error", 32'(error), 32'd1);

        // Stream 20 words through the 8-deep FIFO across pointer wrap
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom), 1'(i >= 3));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            step(1'(($urandom % 60) != 0), 1'($urandom), DW'($urandom), 1'($urandom));

        // Mid-operation reset at count 5
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
        chk("mid_count5", 32'(count), 32'd5);
        step(1'b0, 1'b1, DW'($urandom), 1'b1);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b1, DW'(10'h0AA), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("mid_data",  32'(data_out),  32'h0AA);
        chk("mid_valid", 32'(valid_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
